// File: rtl/mc_model_multi_if.sv
// Convey-style request/response channel bundle for the multi-port MC model.
// Vectors are port-major: port p occupies slice [p*W +: W].
interface mc_model_multi_if #(
    parameter int P  = 1,
    parameter int RC = 32
);
    logic [P-1:0]      mc_rq_vld;
    logic [3*P-1:0]    mc_rq_cmd;
    logic [4*P-1:0]    mc_rq_scmd;
    logic [48*P-1:0]   mc_rq_vadr;
    logic [2*P-1:0]    mc_rq_size;
    logic [RC*P-1:0]   mc_rq_rtnctl;
    logic [64*P-1:0]   mc_rq_data;
    logic [P-1:0]      mc_rq_flush;
    logic [P-1:0]      mc_rq_stall;
    logic [P-1:0]      mc_rs_vld;
    logic [3*P-1:0]    mc_rs_cmd;
    logic [4*P-1:0]    mc_rs_scmd;
    logic [RC*P-1:0]   mc_rs_rtnctl;
    logic [64*P-1:0]   mc_rs_data;
    logic [P-1:0]      mc_rs_stall;

    modport master (
        output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr,
        output mc_rq_size, mc_rq_rtnctl, mc_rq_data, mc_rq_flush,
        output mc_rs_stall,
        input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd,
        input  mc_rs_rtnctl, mc_rs_data
    );

    modport slave (
        input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr,
        input  mc_rq_size, mc_rq_rtnctl, mc_rq_data, mc_rq_flush,
        input  mc_rs_stall,
        output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd,
        output mc_rs_rtnctl, mc_rs_data
    );
endinterface

// File: rtl/mc_model_multi.sv
// Multi-port behavioural memory controller: per-port request FIFOs,
// round-robin grant into one shared RAM, fixed-latency response pipeline.
module mc_model_multi #(
    parameter int NUM_MC_PORTS    = 1,
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int RAM_DEPTH       = 256,
    parameter int FIFO_DEPTH      = 8,
    parameter int LATENCY         = 4,
    parameter int STALL_PERIOD    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_model_multi_if.slave  mc
);
    localparam int P  = NUM_MC_PORTS;
    localparam int RC = MC_RTNCTL_WIDTH;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int IW = $clog2(RAM_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    typedef struct packed {
        logic [2:0]    cmd;
        logic [IW-1:0] idx;
        logic [RC-1:0] rtnctl;
        logic [63:0]   data;
    } req_t;

    typedef struct packed {
        logic          vld;
        logic [PW-1:0] port;
        logic [2:0]    cmd;
        logic [RC-1:0] rtnctl;
        logic [63:0]   data;
    } stg_t;

    req_t          fifo_q [P][FIFO_DEPTH];
    logic [63:0]   mem_q  [RAM_DEPTH];
    logic [FW-1:0] wp_q [P], wp_d [P];
    logic [FW-1:0] rp_q [P], rp_d [P];
    logic [FW:0]   cnt_q [P], cnt_d [P];
    stg_t          pipe_q [LATENCY], pipe_d [LATENCY];
    logic [PW-1:0] rr_q, rr_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [P-1:0]  rq_stall_q, rq_stall_d;

    req_t          in_req [P];
    req_t          head;
    logic [P-1:0]  push, pop;
    logic [PW-1:0] gnt;
    logic          gnt_vld, freeze, inject;
    logic          unused_ok;

    assign unused_ok = ^{mc.mc_rq_scmd, mc.mc_rq_size,
                         mc.mc_rq_flush, mc.mc_rq_vadr};

    always_comb begin
        for (int p = 0; p < P; p++) begin
            in_req[p].cmd    = mc.mc_rq_cmd[p*3 +: 3];
            in_req[p].idx    = mc.mc_rq_vadr[p*48+3 +: IW];
            in_req[p].rtnctl = mc.mc_rq_rtnctl[p*RC +: RC];
            in_req[p].data   = mc.mc_rq_data[p*64 +: 64];
        end
    end

    // Output stage stalled by its own port freezes pipe and arbiter alike.
    always_comb begin
        freeze = 1'b0;
        for (int p = 0; p < P; p++) begin
            if (pipe_q[LATENCY-1].vld &&
                pipe_q[LATENCY-1].port == PW'(p) &&
                mc.mc_rs_stall[p])
                freeze = 1'b1;
        end
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int i = 0; i < P; i++) begin
            for (int c = 0; c < P; c++) begin
                if (!freeze && !gnt_vld && cnt_q[c] != '0 &&
                    ((int'(rr_q) + i) % P) == c) begin
                    gnt_vld = 1'b1;
                    gnt     = PW'(c);
                end
            end
        end
        head = '0;
        for (int p = 0; p < P; p++) begin
            pop[p] = gnt_vld && (gnt == PW'(p));
            if (gnt == PW'(p))
                head = fifo_q[p][rp_q[p]];
        end
        rr_d = rr_q;
        if (gnt_vld)
            rr_d = (gnt == PW'(P-1)) ? '0 : gnt + PW'(1);
    end

    always_comb begin
        inject = (STALL_PERIOD != 0) &&
                 (scnt_q == SW'(STALL_PERIOD-1));
        scnt_d = (STALL_PERIOD == 0 || inject) ? '0 : scnt_q + SW'(1);
        for (int p = 0; p < P; p++) begin
            push[p] = mc.mc_rq_vld[p] &&
                      (cnt_q[p] != (FW+1)'(FIFO_DEPTH));
            cnt_d[p] = cnt_q[p] + (FW+1)'(push[p]) - (FW+1)'(pop[p]);
            wp_d[p]  = wp_q[p] + FW'(push[p]);
            rp_d[p]  = rp_q[p] + FW'(pop[p]);
            rq_stall_d[p] = (cnt_d[p] >= (FW+1)'(FIFO_DEPTH-2)) || inject;
        end
    end

    always_comb begin
        pipe_d = pipe_q;
        if (!freeze) begin
            pipe_d[0] = '0;
            if (gnt_vld && (head.cmd == 3'd1 || head.cmd == 3'd2)) begin
                pipe_d[0].vld    = 1'b1;
                pipe_d[0].port   = gnt;
                pipe_d[0].rtnctl = head.rtnctl;
                pipe_d[0].cmd    = (head.cmd == 3'd1) ? 3'd2 : 3'd3;
                pipe_d[0].data   = (head.cmd == 3'd1) ? mem_q[head.idx] : '0;
            end
            for (int s = 1; s < LATENCY; s++)
                pipe_d[s] = pipe_q[s-1];
        end
    end

    always_comb begin
        mc.mc_rs_vld    = '0;
        mc.mc_rs_cmd    = '0;
        mc.mc_rs_rtnctl = '0;
        mc.mc_rs_data   = '0;
        for (int p = 0; p < P; p++) begin
            if (pipe_q[LATENCY-1].vld &&
                pipe_q[LATENCY-1].port == PW'(p)) begin
                mc.mc_rs_vld[p]            = 1'b1;
                mc.mc_rs_cmd[p*3 +: 3]     = pipe_q[LATENCY-1].cmd;
                mc.mc_rs_rtnctl[p*RC +: RC] = pipe_q[LATENCY-1].rtnctl;
                mc.mc_rs_data[p*64 +: 64]  = pipe_q[LATENCY-1].data;
            end
        end
    end

    assign mc.mc_rs_scmd  = '0;
    assign mc.mc_rq_stall = rq_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < P; p++) begin
                wp_q[p]  <= '0;
                rp_q[p]  <= '0;
                cnt_q[p] <= '0;
            end
            for (int s = 0; s < LATENCY; s++)
                pipe_q[s] <= '0;
            rr_q       <= '0;
            scnt_q     <= '0;
            rq_stall_q <= '0;
        end else begin
            for (int p = 0; p < P; p++) begin
                wp_q[p]  <= wp_d[p];
                rp_q[p]  <= rp_d[p];
                cnt_q[p] <= cnt_d[p];
            end
            for (int s = 0; s < LATENCY; s++)
                pipe_q[s] <= pipe_d[s];
            rr_q       <= rr_d;
            scnt_q     <= scnt_d;
            rq_stall_q <= rq_stall_d;
        end
    end

    // Storage arrays keep their contents across reset.
    always_ff @(posedge clk) begin
        for (int p = 0; p < P; p++) begin
            if (push[p])
                fifo_q[p][wp_q[p]] <= in_req[p];
        end
        if (gnt_vld && head.cmd == 3'd2)
            mem_q[head.idx] <= head.data;
    end
endmodule

// File: tb/tb_mc_model_multi.sv
// Scoreboard bench: a 4-port model (no stall injection) and a 1-port
// model with periodic rq_stall injection.
module tb_mc_model_multi;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    mc_model_multi_if #(.P(4), .RC(32)) ia();
    mc_model_multi_if #(.P(1), .RC(32)) ib();

    mc_model_multi #(
        .NUM_MC_PORTS(4), .MC_RTNCTL_WIDTH(32), .RAM_DEPTH(256),
        .FIFO_DEPTH(8), .LATENCY(4), .STALL_PERIOD(0)
    ) ua (.clk(clk), .rst_n(rst_a_n), .mc(ia.slave));

    mc_model_multi #(
        .NUM_MC_PORTS(1), .MC_RTNCTL_WIDTH(32), .RAM_DEPTH(256),
        .FIFO_DEPTH(8), .LATENCY(4), .STALL_PERIOD(16)
    ) ub (.clk(clk), .rst_n(rst_b_n), .mc(ib.slave));

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] rtn;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t        qa [4][$];
    exp_t        qb [$];
    int          resp_t [4];
    logic [63:0] dv [4];

    task automatic chk(input bit ok, input string nm,
                       input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_a(input int p, input logic [2:0] cmd,
                         input logic [47:0] adr, input logic [31:0] rtn,
                         input logic [63:0] wd, input logic [63:0] ed);
        exp_t e;
        ia.mc_rq_vld[p]             = 1'b1;
        ia.mc_rq_cmd[p*3 +: 3]      = cmd;
        ia.mc_rq_vadr[p*48 +: 48]   = adr;
        ia.mc_rq_rtnctl[p*32 +: 32] = rtn;
        ia.mc_rq_data[p*64 +: 64]   = wd;
        e.rtn = rtn;
        e.due = 0;
        if (cmd == 3'd1) begin
            e.cmd = 3'd2; e.data = ed; qa[p].push_back(e);
        end else if (cmd == 3'd2) begin
            e.cmd = 3'd3; e.data = '0; qa[p].push_back(e);
        end
    endtask

    task automatic set_b(input logic [2:0] cmd, input logic [47:0] adr,
                         input logic [31:0] rtn, input logic [63:0] wd,
                         input logic [63:0] ed);
        exp_t e;
        ib.mc_rq_vld    = 1'b1;
        ib.mc_rq_cmd    = cmd;
        ib.mc_rq_vadr   = adr;
        ib.mc_rq_rtnctl = rtn;
        ib.mc_rq_data   = wd;
        e.rtn = rtn;
        e.due = cyc + 5;
        e.cmd = (cmd == 3'd1) ? 3'd2 : 3'd3;
        e.data = (cmd == 3'd1) ? ed : 64'd0;
        qb.push_back(e);
    endtask

    task automatic wait_a(input int p, input string nm);
        for (int k = 0; k < 50 && !ia.mc_rs_vld[p]; k++)
            @(negedge clk);
        chk(ia.mc_rs_vld[p], nm, 128'(ia.mc_rs_vld), 128'(1 << p));
    endtask

    initial begin : mon_a
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            for (int p = 0; p < 4; p++) begin
                if (rst_a_n && ia.mc_rs_vld[p] && !ia.mc_rs_stall[p]) begin
                    resp_t[p] = cyc;
                    if (qa[p].size() == 0) begin
                        chk(1'b0, "unexpected_rsp_a", 128'(p), 128'(0));
                    end else begin
                        e = qa[p].pop_front();
                        chk(ia.mc_rs_cmd[p*3 +: 3] == e.cmd &&
                            ia.mc_rs_rtnctl[p*32 +: 32] == e.rtn &&
                            ia.mc_rs_data[p*64 +: 64] == e.data &&
                            ia.mc_rs_scmd[p*4 +: 4] == 4'd0,
                            "rsp_a",
                            {ia.mc_rs_cmd[p*3 +: 3],
                             ia.mc_rs_rtnctl[p*32 +: 32],
                             ia.mc_rs_data[p*64 +: 64]},
                            {e.cmd, e.rtn, e.data});
                    end
                end
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_b_n && ib.mc_rs_vld[0] && !ib.mc_rs_stall[0]) begin
                if (qb.size() == 0) begin
                    chk(1'b0, "unexpected_rsp_b", 128'(cyc), 128'(0));
                end else begin
                    e = qb.pop_front();
                    chk(ib.mc_rs_cmd == e.cmd && ib.mc_rs_rtnctl == e.rtn &&
                        ib.mc_rs_data == e.data && ib.mc_rs_scmd == 4'd0,
                        "rsp_b",
                        {ib.mc_rs_cmd, ib.mc_rs_rtnctl, ib.mc_rs_data},
                        {e.cmd, e.rtn, e.data});
                    chk(cyc == e.due, "lat_b", 128'(cyc), 128'(e.due));
                end
            end
        end
    end

    initial begin
        int c0, held, last, pulses;
        logic prev, s;
        bit empty;
        dv[0] = 64'h0123_4567_89AB_CDEF;
        dv[1] = 64'hFEDC_BA98_7654_3210;
        dv[2] = 64'h5555_AAAA_5555_AAAA;
        dv[3] = 64'h0000_0000_0000_0001;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        ia.mc_rq_vld = '0; ia.mc_rq_cmd = '0; ia.mc_rq_scmd = '0;
        ia.mc_rq_vadr = '0; ia.mc_rq_size = '0; ia.mc_rq_rtnctl = '0;
        ia.mc_rq_data = '0; ia.mc_rq_flush = '0; ia.mc_rs_stall = '0;
        ib.mc_rq_vld = '0; ib.mc_rq_cmd = '0; ib.mc_rq_scmd = '0;
        ib.mc_rq_vadr = '0; ib.mc_rq_size = '0; ib.mc_rq_rtnctl = '0;
        ib.mc_rq_data = '0; ib.mc_rq_flush = '0; ib.mc_rs_stall = '0;
        repeat (3) @(negedge clk);
        chk(ia.mc_rs_vld == 4'd0, "rst_rs_vld_a", 128'(ia.mc_rs_vld), 0);
        chk(ia.mc_rq_stall == 4'd0, "rst_rq_stall_a",
            128'(ia.mc_rq_stall), 0);
        chk(ib.mc_rs_vld == 1'b0 && ib.mc_rq_stall == 1'b0,
            "rst_b", 128'({ib.mc_rs_vld, ib.mc_rq_stall}), 0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        repeat (2) @(negedge clk);

        // single port: write then read back, fixed latency
        set_b(3'd2, 48'h10, 32'd5, 64'hDEAD_BEEF, 64'd0);
        @(negedge clk);
        set_b(3'd1, 48'h10, 32'd6, 64'd0, 64'hDEAD_BEEF);
        @(negedge clk);
        ib.mc_rq_vld = 1'b0;
        repeat (10) @(negedge clk);

        // injected rq_stall pulses on the single-port model
        last = -1; pulses = 0; prev = 1'b0;
        repeat (70) begin
            @(negedge clk);
            #1;
            s = ib.mc_rq_stall[0];
            if (s) begin
                chk(!prev, "stall_width", 128'(prev), 0);
                if (last >= 0)
                    chk(cyc - last == 16, "stall_period",
                        128'(cyc - last), 128'(16));
                last = cyc;
                pulses++;
            end
            prev = s;
        end
        chk(pulses >= 4, "stall_pulses", 128'(pulses), 128'(4));

        // four ports write, then all read in the same cycle
        @(negedge clk);
        for (int p = 0; p < 4; p++)
            set_a(p, 3'd2, 48'h100 + 48'(8*p), 32'(100+p), dv[p], 64'd0);
        @(negedge clk);
        ia.mc_rq_vld = '0;
        repeat (12) @(negedge clk);
        c0 = cyc;
        set_a(0, 3'd1, 48'h100, 32'h10, 64'd0, dv[0]);
        set_a(1, 3'd1, 48'h108, 32'h11, 64'd0, dv[1]);
        set_a(2, 3'd1, 48'h110, 32'h12, 64'd0, dv[2]);
        set_a(3, 3'd1, 48'h900, 32'h13, 64'd0, dv[0]);
        @(negedge clk);
        ia.mc_rq_vld = '0;
        repeat (12) @(negedge clk);
        for (int p = 0; p < 4; p++)
            chk(resp_t[p] - c0 == 5 + p, "rr_order_latency",
                128'(resp_t[p] - c0), 128'(5 + p));

        // unknown command is swallowed
        set_a(2, 3'd5, 48'h110, 32'h60, 64'd0, 64'd0);
        @(negedge clk);
        set_a(2, 3'd1, 48'h110, 32'h61, 64'd0, dv[2]);
        @(negedge clk);
        ia.mc_rq_vld = '0;
        repeat (10) @(negedge clk);

        // back-pressure fills FIFO 0 to 7 entries
        ia.mc_rs_stall[0] = 1'b1;
        set_a(0, 3'd1, 48'h100, 32'h40, 64'd0, dv[0]);
        @(negedge clk);
        ia.mc_rq_vld = '0;
        wait_a(0, "t3_head");
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 5)
                chk(ia.mc_rq_stall[0] == 1'b0, "rq_stall_at5",
                    128'(ia.mc_rq_stall[0]), 0);
            if (i == 6)
                chk(ia.mc_rq_stall[0] == 1'b1, "rq_stall_at6",
                    128'(ia.mc_rq_stall[0]), 1);
            set_a(0, 3'd1, 48'h100, 32'(32'h30 + i), 64'd0, dv[0]);
        end
        @(negedge clk);
        ia.mc_rq_vld = '0;
        repeat (3) @(negedge clk);
        ia.mc_rs_stall[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk(ia.mc_rq_stall[0] == 1'b0, "rq_stall_drained",
            128'(ia.mc_rq_stall[0]), 0);

        // port-1 response held under stall, port 0 blocked behind it
        ia.mc_rs_stall[1] = 1'b1;
        set_a(1, 3'd1, 48'h108, 32'h51, 64'd0, dv[1]);
        @(negedge clk);
        ia.mc_rq_vld = '0;
        set_a(0, 3'd1, 48'h100, 32'h50, 64'd0, dv[0]);
        @(negedge clk);
        set_a(0, 3'd1, 48'h118, 32'h52, 64'd0, dv[3]);
        @(negedge clk);
        ia.mc_rq_vld = '0;
        wait_a(1, "t4_head");
        held = 0;
        repeat (9) begin
            @(negedge clk);
            #1;
            if (ia.mc_rs_vld == 4'b0010 && ia.mc_rs_data[127:64] == dv[1] &&
                ia.mc_rs_rtnctl[63:32] == 32'h51)
                held++;
        end
        chk(held == 9, "hold_stable", 128'(held), 128'(9));
        @(negedge clk);
        ia.mc_rs_stall[1] = 1'b0;
        repeat (20) @(negedge clk);

        // reset while a response is held and writes are in flight
        ia.mc_rs_stall[2] = 1'b1;
        set_a(2, 3'd1, 48'h110, 32'h70, 64'd0, dv[2]);
        @(negedge clk);
        ia.mc_rq_vld = '0;
        wait_a(2, "t6_head");
        set_a(0, 3'd2, 48'h300, 32'h71, 64'h11, 64'd0);
        set_a(1, 3'd2, 48'h308, 32'h72, 64'h22, 64'd0);
        @(negedge clk);
        ia.mc_rq_vld = '0;
        rst_a_n = 1'b0;
        #1;
        chk(ia.mc_rs_vld == 4'd0 && ia.mc_rs_data == '0, "rst_mid_rs",
            128'(ia.mc_rs_vld), 0);
        chk(ia.mc_rq_stall == 4'd0, "rst_mid_rq_stall",
            128'(ia.mc_rq_stall), 0);
        for (int p = 0; p < 4; p++)
            qa[p].delete();
        ia.mc_rs_stall = '0;
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        @(negedge clk);
        set_a(1, 3'd1, 48'h108, 32'h73, 64'd0, dv[1]);
        set_a(3, 3'd1, 48'h118, 32'h74, 64'd0, dv[3]);
        @(negedge clk);
        ia.mc_rq_vld = '0;

        for (int k = 0; k < 300; k++) begin
            empty = (qb.size() == 0);
            for (int p = 0; p < 4; p++)
                if (qa[p].size() != 0) empty = 1'b0;
            if (empty) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        for (int p = 0; p < 4; p++)
            chk(qa[p].size() == 0, "drain_a", 128'(qa[p].size()), 0);
        chk(qb.size() == 0, "drain_b", 128'(qb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
